// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
// Load/store size codes and the wait-state FSM encoding.
package mem_stage_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] LS_WORD = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_BYTE = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/mem_byte_ram.sv
// Word-organised RAM with four independently written byte lanes.
// Synchronous write per lane, combinational read, no reset.
module mem_byte_ram
  import mem_stage_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
      if (we[l]) mem[addr] <= wdata[8*l +: 8];
    end

    assign rdata[8*l +: 8] = mem[addr];
  end

endmodule

// File: rtl/mem_stage_pipelined.sv
// MEM stage: byte/half/word RAM access with wait states, branch resolve, MEM/WB register.
// Optional MEM_MISALIGN_CHECK_EN flags and suppresses misaligned word/half accesses.
module mem_stage_pipelined
  import mem_stage_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0,
  parameter int REG_ADDR_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_mem_read,
  input  logic                  in_mem_write,
  input  logic                  in_write_back,
  input  logic                  in_mem_to_reg,
  input  logic                  in_zero,
  input  logic                  in_branch,
  input  logic [1:0]            in_load_mode,
  input  logic                  in_load_unsigned,
  input  logic [1:0]            in_store_mode,
  input  logic [DATA_W-1:0]     in_address,
  input  logic [DATA_W-1:0]     in_write_data,
  input  logic [REG_ADDR_W-1:0] in_dest_reg,
  output logic                  stall,
  output logic                  pc_src,
  output logic                  wb_valid,
  output logic                  write_back_out,
  output logic                  mem_to_reg,
  output logic [DATA_W-1:0]     read_data,
  output logic [DATA_W-1:0]     address_out,
  output logic [REG_ADDR_W-1:0] dest_reg_out,
  output logic                  misalign_out
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t      state;
  logic [3:0]  cnt;
  logic        mem_op;
  logic        wait_entry;
  logic        fin;
  logic        mis;
  logic [3:0]  wmask;
  logic [3:0]  we;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rword;
  logic [15:0] lh;
  logic [7:0]  lb;
  logic [DATA_W-1:0] ld_ext;
  logic [DATA_W-1:0] rd_val;
  logic        unused_addr;

  assign unused_addr = ^in_address;

  assign mem_op     = in_valid & (in_mem_read | in_mem_write);
  assign wait_entry = (state == ST_IDLE) & mem_op & (WS != 4'd0);
  assign stall      = wait_entry | ((state == ST_WAIT) & (cnt != 4'd0));
  assign fin        = ~stall;
  assign pc_src     = in_valid & in_branch & in_zero & ~stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (wait_entry) begin
            state <= ST_WAIT;
            cnt   <= WS - 4'd1;
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) state <= ST_IDLE;
          else             cnt   <= cnt - 4'd1;
        end
      endcase
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  always_comb begin
    mis = 1'b0;
    if (in_valid & in_mem_write)
      mis = (in_store_mode == LS_WORD && in_address[1:0] != 2'b00)
          || (in_store_mode == LS_HALF && in_address[0]);
    else if (in_valid & in_mem_read)
      mis = (in_load_mode == LS_HALF) ? in_address[0]
          : (in_load_mode != LS_BYTE && in_address[1:0] != 2'b00);
  end
`else
  assign mis = 1'b0;
`endif

  always_comb begin
    wmask = 4'b0000;
    wdata = in_write_data;
    unique case (in_store_mode)
      LS_WORD: wmask = 4'b1111;
      LS_HALF: begin
        wmask = in_address[1] ? 4'b1100 : 4'b0011;
        wdata = {2{in_write_data[15:0]}};
      end
      LS_BYTE: begin
        wmask = 4'b0001 << in_address[1:0];
        wdata = {4{in_write_data[7:0]}};
      end
      default: wmask = 4'b0000;
    endcase
  end

  // Commit only on the final cycle so a store lands exactly once.
  assign we = (fin & in_valid & in_mem_write & ~mis & ~rst) ? wmask : 4'b0000;

  mem_byte_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .addr (in_address[AW+1:2]),
    .wdata(wdata),
    .rdata(rword)
  );

  assign lh = in_address[1] ? rword[31:16] : rword[15:0];
  assign lb = in_address[0] ? lh[15:8] : lh[7:0];

  always_comb begin
    unique case (in_load_mode)
      LS_HALF: ld_ext = {{16{~in_load_unsigned & lh[15]}}, lh};
      LS_BYTE: ld_ext = {{24{~in_load_unsigned & lb[7]}}, lb};
      default: ld_ext = rword;
    endcase
  end

  assign rd_val = (in_mem_read & ~in_mem_write & ~mis) ? ld_ext : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid       <= 1'b0;
      write_back_out <= 1'b0;
      mem_to_reg     <= 1'b0;
      read_data      <= '0;
      address_out    <= '0;
      dest_reg_out   <= '0;
      misalign_out   <= 1'b0;
    end else if (fin & in_valid) begin
      wb_valid       <= 1'b1;
      write_back_out <= in_write_back & ~mis;
      mem_to_reg     <= in_mem_to_reg;
      read_data      <= rd_val;
      address_out    <= in_address;
      dest_reg_out   <= in_dest_reg;
      misalign_out   <= mis;
    end else begin
      wb_valid       <= 1'b0;
      write_back_out <= 1'b0;
      misalign_out   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage_pipelined.sv
// Directed bench for mem_stage_pipelined: one instance with no wait states, one with three.
// Honours MEM_MISALIGN_CHECK_EN when choosing misaligned-load expectations.
module tb_mem_stage_pipelined;

  typedef struct packed {
    logic        valid;
    logic        rd;
    logic        wr;
    logic        wb;
    logic        m2r;
    logic        zero;
    logic        br;
    logic [1:0]  lm;
    logic        lu;
    logic [1:0]  sm;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [4:0]  dr;
  } in_t;

  logic clk = 1'b0;
  logic rst;
  in_t  a, b;
  int   checks = 0;
  int   errors = 0;

  logic s0, p0, v0, w0, m0, x0;
  logic [31:0] r0, ad0;
  logic [4:0]  d0;
  logic s3, p3, v3, w3, m3, x3;
  logic [31:0] r3, ad3;
  logic [4:0]  d3;

  always #5 clk = ~clk;

  mem_stage_pipelined #(.WAIT_STATES(0)) u0 (
    .clk(clk), .rst(rst),
    .in_valid(a.valid), .in_mem_read(a.rd), .in_mem_write(a.wr),
    .in_write_back(a.wb), .in_mem_to_reg(a.m2r), .in_zero(a.zero),
    .in_branch(a.br), .in_load_mode(a.lm), .in_load_unsigned(a.lu),
    .in_store_mode(a.sm), .in_address(a.addr), .in_write_data(a.wd),
    .in_dest_reg(a.dr),
    .stall(s0), .pc_src(p0), .wb_valid(v0), .write_back_out(w0),
    .mem_to_reg(m0), .read_data(r0), .address_out(ad0),
    .dest_reg_out(d0), .misalign_out(x0)
  );

  mem_stage_pipelined #(.WAIT_STATES(3)) u3 (
    .clk(clk), .rst(rst),
    .in_valid(b.valid), .in_mem_read(b.rd), .in_mem_write(b.wr),
    .in_write_back(b.wb), .in_mem_to_reg(b.m2r), .in_zero(b.zero),
    .in_branch(b.br), .in_load_mode(b.lm), .in_load_unsigned(b.lu),
    .in_store_mode(b.sm), .in_address(b.addr), .in_write_data(b.wd),
    .in_dest_reg(b.dr),
    .stall(s3), .pc_src(p3), .wb_valid(v3), .write_back_out(w3),
    .mem_to_reg(m3), .read_data(r3), .address_out(ad3),
    .dest_reg_out(d3), .misalign_out(x3)
  );

  function automatic in_t nop();
    nop = '0;
  endfunction

  function automatic in_t ld(logic [31:0] ad, logic [1:0] m, logic u, logic [4:0] r);
    ld = '0;
    ld.valid = 1'b1; ld.rd = 1'b1; ld.wb = 1'b1; ld.m2r = 1'b1;
    ld.lm = m; ld.lu = u; ld.addr = ad; ld.dr = r;
  endfunction

  function automatic in_t st(logic [31:0] ad, logic [31:0] d, logic [1:0] m);
    st = '0;
    st.valid = 1'b1; st.wr = 1'b1; st.sm = m; st.addr = ad; st.wd = d;
  endfunction

  function automatic in_t brz(logic z);
    brz = '0;
    brz.valid = 1'b1; brz.br = 1'b1; brz.zero = z;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One instruction on the zero-wait instance; it must never stall.
  task automatic op0(input in_t v);
    a = v;
    #1;
    checks++;
    if (s0 !== 1'b0) begin
      errors++; $display("FAIL ws0_stall got=%b exp=0", s0);
    end
    tick();
    a = nop();
  endtask

  // Hold one instruction on the 3-wait instance until its final cycle.
  task automatic run3(input in_t v, output int stalls, output int pcs,
                      output int lat, output int wbat);
    logic fin;
    logic done;
    stalls = 0; pcs = 0; lat = 0; wbat = 0; done = 1'b0;
    b = v;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (s3) stalls++;
      if (p3) pcs++;
      fin = ~s3;
      tick();
      lat++;
      if (v3 === 1'b1 && wbat == 0) wbat = lat;
      if (fin) done = 1'b1;
    end
    b = nop();
    if (!done) begin
      checks++; errors++;
      $display("FAIL ws3_timeout got=stalled exp=final within 20 cycles");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a = nop(); b = nop();
    tick(); tick();
    checks++;
    if ({v0, w0, m0, x0, r0, ad0, d0, s0} !== '0) begin
      errors++; $display("FAIL reset_u0 got=%b%b%b%b %h %h %h %b exp=0",
                         v0, w0, m0, x0, r0, ad0, d0, s0);
    end
    checks++;
    if ({v3, w3, m3, x3, r3, ad3, d3, s3} !== '0) begin
      errors++; $display("FAIL reset_u3 got=%b%b%b%b %h %h %h %b exp=0",
                         v3, w3, m3, x3, r3, ad3, d3, s3);
    end
    rst = 1'b0;
  endtask

  task automatic test_word();
    op0(st(32'h10, 32'hDEADBEEF, 2'b00));
    checks++;
    if ({v0, w0} !== 2'b10) begin
      errors++; $display("FAIL t1_store_wb got=%b exp=10", {v0, w0});
    end
    op0(ld(32'h10, 2'b00, 1'b0, 5'd5));
    checks++;
    if (r0 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL t1_load got=%h exp=deadbeef", r0);
    end
    checks++;
    if ({v0, w0, m0, d0, ad0} !== {3'b111, 5'd5, 32'h10}) begin
      errors++; $display("FAIL t1_fields got=%b%b%b %h %h exp=111 05 10",
                         v0, w0, m0, d0, ad0);
    end
    op0(nop());
    checks++;
    if ({v0, w0, r0} !== {2'b00, 32'hDEADBEEF}) begin
      errors++; $display("FAIL t1_bubble got=%b%b %h exp=00 deadbeef", v0, w0, r0);
    end
  endtask

  task automatic test_byte_half();
    op0(st(32'h13, 32'h12345680, 2'b10));
    op0(ld(32'h13, 2'b10, 1'b0, 5'd1));
    checks++;
    if (r0 !== 32'hFFFFFF80) begin
      errors++; $display("FAIL t2_lb_signed got=%h exp=ffffff80", r0);
    end
    op0(ld(32'h13, 2'b10, 1'b1, 5'd1));
    checks++;
    if (r0 !== 32'h00000080) begin
      errors++; $display("FAIL t2_lbu got=%h exp=00000080", r0);
    end
    op0(ld(32'h10, 2'b00, 1'b0, 5'd1));
    checks++;
    if (r0 !== 32'h80ADBEEF) begin
      errors++; $display("FAIL t2_lw got=%h exp=80adbeef", r0);
    end
    op0(ld(32'h12, 2'b01, 1'b0, 5'd1));
    checks++;
    if (r0 !== 32'hFFFF80AD) begin
      errors++; $display("FAIL t2_lh_signed got=%h exp=ffff80ad", r0);
    end
    op0(ld(32'h11, 2'b10, 1'b1, 5'd1));
    checks++;
    if (r0 !== 32'h000000BE) begin
      errors++; $display("FAIL t2_lbu_lane1 got=%h exp=000000be", r0);
    end
    op0(st(32'h12, 32'hAAAA7FFF, 2'b01));
    op0(st(32'h10, 32'h0, 2'b11));
    op0(ld(32'h1010, 2'b00, 1'b0, 5'd1));
    checks++;
    if (r0 !== 32'h7FFFBEEF) begin
      errors++; $display("FAIL t2_sh_wrap got=%h exp=7fffbeef", r0);
    end
  endtask

  task automatic test_stall();
    int st_n, pc_n, lat, wbat;
    run3(st(32'h10, 32'h11223344, 2'b00), st_n, pc_n, lat, wbat);
    checks++;
    if ({st_n, lat, wbat} !== {32'd3, 32'd4, 32'd4}) begin
      errors++; $display("FAIL t3_store_timing got=%0d/%0d/%0d exp=3/4/4", st_n, lat, wbat);
    end
    run3(ld(32'h10, 2'b00, 1'b0, 5'd7), st_n, pc_n, lat, wbat);
    checks++;
    if ({st_n, lat, wbat} !== {32'd3, 32'd4, 32'd4}) begin
      errors++; $display("FAIL t3_load_timing got=%0d/%0d/%0d exp=3/4/4", st_n, lat, wbat);
    end
    checks++;
    if ({r3, d3, w3} !== {32'h11223344, 5'd7, 1'b1}) begin
      errors++; $display("FAIL t3_load_data got=%h %h %b exp=11223344 07 1", r3, d3, w3);
    end
    tick();
    checks++;
    if (v3 !== 1'b0) begin
      errors++; $display("FAIL t3_wb_once got=%b exp=0", v3);
    end
  endtask

  task automatic test_branch();
    int st_n, pc_n, lat, wbat;
    run3(ld(32'h10, 2'b00, 1'b0, 5'd2), st_n, pc_n, lat, wbat);
    checks++;
    if (pc_n !== 0) begin
      errors++; $display("FAIL t4_load_pc got=%0d exp=0", pc_n);
    end
    run3(brz(1'b1), st_n, pc_n, lat, wbat);
    checks++;
    if ({pc_n, st_n, lat} !== {32'd1, 32'd0, 32'd1}) begin
      errors++; $display("FAIL t4_br_taken got=%0d/%0d/%0d exp=1/0/1", pc_n, st_n, lat);
    end
    begin
      in_t v;
      v = brz(1'b1);
      v.rd = 1'b1;
      v.addr = 32'h10;
      run3(v, st_n, pc_n, lat, wbat);
    end
    checks++;
    if ({pc_n, st_n} !== {32'd1, 32'd3}) begin
      errors++; $display("FAIL t4_br_stalled got=%0d/%0d exp=1/3", pc_n, st_n);
    end
    run3(brz(1'b0), st_n, pc_n, lat, wbat);
    checks++;
    if (pc_n !== 0) begin
      errors++; $display("FAIL t4_br_not_taken got=%0d exp=0", pc_n);
    end
  endtask

  task automatic test_reset_mid();
    int st_n, pc_n, lat, wbat;
    run3(st(32'h20, 32'hCAFEF00D, 2'b00), st_n, pc_n, lat, wbat);
    b = st(32'h20, 32'h00001234, 2'b00);
    #1;
    checks++;
    if (s3 !== 1'b1) begin
      errors++; $display("FAIL t5_issue_stall got=%b exp=1", s3);
    end
    tick(); tick();
    rst = 1'b1;
    b = nop();
    tick();
    rst = 1'b0;
    checks++;
    if ({v3, w3, m3, x3, r3, ad3, d3, s3} !== '0) begin
      errors++; $display("FAIL t5_reset_out got=%b%b%b%b %h %h %h %b exp=0",
                         v3, w3, m3, x3, r3, ad3, d3, s3);
    end
    run3(ld(32'h20, 2'b00, 1'b0, 5'd4), st_n, pc_n, lat, wbat);
    checks++;
    if (r3 !== 32'hCAFEF00D) begin
      errors++; $display("FAIL t5_store_dropped got=%h exp=cafef00d", r3);
    end
  endtask

  task automatic test_misalign();
    int st_n, pc_n, lat, wbat;
    run3(ld(32'h22, 2'b00, 1'b0, 5'd3), st_n, pc_n, lat, wbat);
    checks++;
    if (lat !== 4) begin
      errors++; $display("FAIL t6_timing got=%0d exp=4", lat);
    end
`ifdef MEM_MISALIGN_CHECK_EN
    checks++;
    if ({v3, x3, w3, r3} !== {3'b110, 32'h0}) begin
      errors++; $display("FAIL t6_misalign got=%b%b%b %h exp=110 00000000", v3, x3, w3, r3);
    end
`else
    checks++;
    if ({v3, x3, w3, r3} !== {3'b101, 32'hCAFEF00D}) begin
      errors++; $display("FAIL t6_aligned_down got=%b%b%b %h exp=101 cafef00d", v3, x3, w3, r3);
    end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a = nop();
    b = nop();
    rst = 1'b1;
    test_reset();
    test_word();
    test_byte_half();
    test_stall();
    test_branch();
    test_reset_mid();
    test_misalign();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
